mac_unit: RTL and testbench
===========================

# mac_unit

Multi-cycle multiply-accumulate responder for the custom MAC instruction family issued by the integer execution unit. Captures forwarded Execute-stage operands when `mac_validE` is asserted, holds the instruction in Execute via a busy/stall handshake while an iterative 8-bit-per-cycle multiplier runs, and updates a private 2·XLEN accumulator. The result is carried through its own Memory/Writeback pipeline registers to the integer writeback mux.

## Interface
- `P`, (none), `cvw_t` configuration; uses `P.XLEN` (32 or 64).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset; `reset==0` at a rising edge resets.
- `mac_validE`  in  1  MAC-family instruction in Execute.
- `Funct3E`  in  3  operation select.
- `ForwardedSrcAE`, `ForwardedSrcBE`  in  XLEN  forwarded operands.
- `StallE`, `FlushE`, `StallM`, `FlushM`, `StallW`, `FlushW`  in  1  hazard-unit controls.
- `MACBusyE`  out  1  to hazard unit; stalls Execute while computing.
- `MACValidW`  out  1  Writeback holds a completed MAC-family result.
- `MACResultW`  out  XLEN  result for the writeback mux.

## Operation
- Operations (`Funct3E`):
  - `000` MAC: signed, `acc += A*B`; result is `acc_new[XLEN-1:0]`.
  - `001` MACU: same as MAC, unsigned.
  - `010` MACCLR: result is old `acc[XLEN-1:0]`; `acc = 0`.
  - `011` MACRDH: result is `acc[2XLEN-1:XLEN]`; `acc` unchanged.
  - Other encodings behave as MACRDH. Decode rejects them as illegal.
- Arithmetic:
  - Product width is 2·XLEN.
  - Signed MAC multiplies magnitudes and negates the product in the ADD cycle when the operand signs differ.
  - Accumulator add wraps modulo 2^(2·XLEN). No saturation, no flags.
- FSM states: IDLE, MUL, ADD, DONE.
  - IDLE→MUL: `mac_validE & ~FlushE` with MAC/MACU. Latch operands and magnitudes; clear the partial product; counter = 0.
  - IDLE→DONE: `mac_validE & ~FlushE` with CLR/RDH. Compute the result.
  - MUL: each cycle adds `multiplicand * mplier[7:0]` shifted by 8·count, then shifts the multiplier right 8. After `N = XLEN/8` iterations (count = N-1) go to ADD.
  - ADD: apply the sign fix, form `acc + product` into the pending-accumulator and result registers, then go to DONE.
  - DONE: result held stable. Go to IDLE when `~StallE`.
- `MACBusyE = mac_validE & (state==IDLE | MUL | ADD)`. It is deasserted in DONE.
- Accumulator commit: `acc` is written only on the DONE cycle with `~StallE & ~FlushE`, i.e. when the instruction leaves Execute. CLR commits 0; MAC/MACU commit the pending value.
- `FlushE` in any state returns the FSM to IDLE the next cycle with no accumulator change.
- E→M register:
  - Captures `{valid, result}` when `~StallM`.
  - Valid is `DONE & ~StallE & ~FlushE`.
  - Valid clears on `FlushM`.
- M→W register: same rules using `StallW`/`FlushW`.
- Reset values:
  - state IDLE, acc 0, all pipeline registers 0.
  - `MACBusyE` 0, `MACValidW` 0, `MACResultW` 0.

## Timing
- MAC/MACU stall cycles: 1 (IDLE issue) + N (MUL) + 1 (ADD) = N+2. That is 10 for RV64 and 6 for RV32. The instruction leaves Execute on the cycle after the first DONE cycle unless stalled externally.
- CLR/RDH: 1 stall cycle.
- Back-to-back MACs: the second sees the committed accumulator of the first, because commit happens at Execute exit before the next instruction can start.
- A reset asserted mid-operation takes priority over everything: FSM goes to IDLE and `acc` to 0 on that edge.
- External `StallE` while in DONE holds the result; it does not recommit or restart.
- `MACBusyE` is combinational from state and `mac_validE`. There is no combinational path from `ForwardedSrc*E` to `MACBusyE`.

## Structure
- Shared package: the MAC funct3 encodings and a `macstate_t` enum for IDLE/MUL/ADD/DONE. These live beside the other cvw enums.
- Sub-module `mac_mul8`: iterative 8-bit-per-cycle unsigned multiplier datapath. It holds the multiplicand, shifting multiplier, partial product and counter, with `start`/`last` signals. The FSM, sign fix, accumulator and pipeline registers stay in `mac_unit`.

## Test plan
- RV64, acc=0, MAC A=3 B=-5 → `MACBusyE` high exactly 10 cycles; `MACResultW`=0xFFFF_FFFF_FFFF_FFF1 two cycles after Execute exit; MACRDH then returns all-ones.
- MACU A=B=0xFFFF_FFFF_FFFF_FFFF, then MACRDH → high word 0xFFFF_FFFF_FFFF_FFFE; low-word result 0x1.
- Accumulator wrap: acc=2^128−1 (preloaded via MACUs), MACU 1×1 → acc=0; MACRDH returns 0.
- `FlushE` asserted in MUL count 4 → FSM IDLE next cycle, `MACValidW` never set, subsequent MACRDH shows unchanged acc.
- MACCLR with acc low=0x1234 → result 0x1234; following MACRDH and MAC 0×0 both return 0.
- `reset`=0 for one edge during ADD → `MACBusyE`=0, acc=0, `MACValidW`=0 next cycle; `StallE` held 3 extra cycles in DONE → single commit only.

Source files
------------

// File: rtl/mac_unit_pkg.sv
// -----------------------------------------------------------------------------
// mac_unit_pkg
// Shared definitions for the MAC instruction family:
//   - cvw_t        : core configuration record (only XLEN is consumed here)
//   - MAC_F3_*     : funct3 encodings of the MAC family
//   - macstate_t   : sequencing states of the MAC responder
//   - mac_is_mul() : true for the encodings that run the multiplier
// -----------------------------------------------------------------------------
package mac_unit_pkg;

    typedef struct packed {
        int XLEN;
    } cvw_t;

    localparam cvw_t CVW_RV64 = '{XLEN: 64};
    localparam cvw_t CVW_RV32 = '{XLEN: 32};

    localparam logic [2:0] MAC_F3_MAC    = 3'b000;  // signed   acc += A*B
    localparam logic [2:0] MAC_F3_MACU   = 3'b001;  // unsigned acc += A*B
    localparam logic [2:0] MAC_F3_MACCLR = 3'b010;  // read low word, clear acc
    localparam logic [2:0] MAC_F3_MACRDH = 3'b011;  // read high word

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } macstate_t;

    function automatic logic mac_is_mul(input logic [2:0] funct3);
        return (funct3 == MAC_F3_MAC) || (funct3 == MAC_F3_MACU);
    endfunction

endpackage

// File: rtl/mac_unit_if.sv
// -----------------------------------------------------------------------------
// mac_unit_if
// Execute-stage issue bus, hazard controls and writeback result of the MAC
// responder.
//   master : pipeline side (drives operands, funct3, stalls/flushes)
//   slave  : mac_unit (drives MACBusyE, MACValidW, MACResultW)
// -----------------------------------------------------------------------------
interface mac_unit_if #(
    parameter int XLEN = 64
);
    logic            mac_validE;
    logic [2:0]      Funct3E;
    logic [XLEN-1:0] ForwardedSrcAE;
    logic [XLEN-1:0] ForwardedSrcBE;
    logic            StallE;
    logic            FlushE;
    logic            StallM;
    logic            FlushM;
    logic            StallW;
    logic            FlushW;
    logic            MACBusyE;
    logic            MACValidW;
    logic [XLEN-1:0] MACResultW;

    modport master (
        output mac_validE, Funct3E, ForwardedSrcAE, ForwardedSrcBE,
        output StallE, FlushE, StallM, FlushM, StallW, FlushW,
        input  MACBusyE, MACValidW, MACResultW
    );

    modport slave (
        input  mac_validE, Funct3E, ForwardedSrcAE, ForwardedSrcBE,
        input  StallE, FlushE, StallM, FlushM, StallW, FlushW,
        output MACBusyE, MACValidW, MACResultW
    );

endinterface

// File: rtl/mac_mul8.sv
// -----------------------------------------------------------------------------
// mac_mul8
// Iterative unsigned XLEN x XLEN multiplier retiring 8 multiplier bits per
// cycle. The product is complete after XLEN/8 run cycles.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   start             load operands, clear partial product and counter
//   run               perform one 8-bit iteration this cycle
//   multiplicand_in   unsigned multiplicand (sampled on start)
//   multiplier_in     unsigned multiplier   (sampled on start)
//   last              current run cycle is the final iteration
//   product           2*XLEN partial/final product
// -----------------------------------------------------------------------------
module mac_mul8 #(
    parameter int XLEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              run,
    input  logic [XLEN-1:0]   multiplicand_in,
    input  logic [XLEN-1:0]   multiplier_in,
    output logic              last,
    output logic [2*XLEN-1:0] product
);

    localparam int N  = XLEN / 8;
    localparam int CW = $clog2(N);

    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [2*XLEN-1:0] partial_q;
    logic [CW-1:0]     count_q;
    logic [2*XLEN-1:0] term;

    // Contribution of the current multiplier byte, aligned to its weight.
    assign term = ({{XLEN{1'b0}}, mcand_q} * {{(2*XLEN-8){1'b0}}, mplier_q[7:0]})
                  << {count_q, 3'b000};

    assign last    = (count_q == CW'(N - 1));
    assign product = partial_q;

    // NOTE: reset is synchronous -- it is only a priority branch inside the
    // clocked block, so the sensitivity list holds the clock alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            partial_q <= '0;
            count_q   <= '0;
        end else if (start) begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            mcand_q   <= multiplicand_in;
            mplier_q  <= multiplier_in;
            partial_q <= '0;
            count_q   <= '0;
        end else if (run) begin
            partial_q <= partial_q + term;
            mplier_q  <= mplier_q >> 8;
            count_q   <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
// Multi-cycle multiply-accumulate responder. Captures Execute operands, holds
// the instruction in Execute (MACBusyE) while mac_mul8 iterates, keeps a
// private 2*XLEN accumulator and carries the result through its own M and W
// pipeline registers.
// Ports:
//   clk    clock
//   reset  synchronous active-low reset
//   bus    mac_unit_if.slave: issue bus, hazard controls, busy/result outputs
// -----------------------------------------------------------------------------
module mac_unit
    import mac_unit_pkg::*;
#(
    parameter cvw_t P = CVW_RV64
) (
    input logic         clk,
    input logic         reset,
    mac_unit_if.slave   bus
);

    localparam int XLEN = P.XLEN;
    localparam int W2   = 2 * XLEN;

    macstate_t       state_q, state_d;
    logic            issue;
    logic            is_mul_op;
    logic            signed_op;
    logic            a_sign, b_sign;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            mul_start, mul_run, mul_last;
    logic [W2-1:0]   product;
    logic [W2-1:0]   sum;
    logic            commit;

    logic [2:0]      op_q;
    logic            neg_q;
    logic [W2-1:0]   acc_q;
    logic [W2-1:0]   acc_pend_q;
    logic [XLEN-1:0] result_q;

    logic            valid_m_q, valid_w_q;
    logic [XLEN-1:0] result_m_q, result_w_q;

    // ---------------------------------------------------------------- decode
    assign issue     = bus.mac_validE & ~bus.FlushE;
    assign is_mul_op = mac_is_mul(bus.Funct3E);
    assign signed_op = (bus.Funct3E == MAC_F3_MAC);

    // Signed MAC multiplies magnitudes; the product sign is restored in ADD.
    assign a_sign = signed_op & bus.ForwardedSrcAE[XLEN-1];
    assign b_sign = signed_op & bus.ForwardedSrcBE[XLEN-1];
    assign a_mag  = a_sign ? -bus.ForwardedSrcAE : bus.ForwardedSrcAE;
    assign b_mag  = b_sign ? -bus.ForwardedSrcBE : bus.ForwardedSrcBE;

    // ------------------------------------------------------------ multiplier
    mac_mul8 #(.XLEN(XLEN)) u_mul (
        .clk             (clk),
        .reset           (reset),
        .start           (mul_start),
        .run             (mul_run),
        .multiplicand_in (a_mag),
        .multiplier_in   (b_mag),
        .last            (mul_last),
        .product         (product)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        mul_start = 1'b0;
        mul_run   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d   = is_mul_op ? MUL : DONE;
                    mul_start = is_mul_op;
                end
            end
            MUL: begin
                if (bus.FlushE) begin
                    state_d = IDLE;
                end else begin
                    mul_run = 1'b1;
                    if (mul_last) state_d = ADD;
                end
            end
            ADD: begin
                state_d = bus.FlushE ? IDLE : DONE;
            end
            DONE: begin
                // Leave when the instruction exits Execute or is squashed.
                if (bus.FlushE || !bus.StallE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Busy depends only on state and the valid bit, never on operands.
    assign bus.MACBusyE = bus.mac_validE & (state_q != DONE);

    // ------------------------------------------------------ accumulator path
    assign sum    = acc_q + (neg_q ? -product : product);
    assign commit = (state_q == DONE) & ~bus.StallE & ~bus.FlushE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q       <= MAC_F3_MACRDH;
            neg_q      <= 1'b0;
            acc_q      <= '0;
            acc_pend_q <= '0;
            result_q   <= '0;
        end else begin
            if (state_q == IDLE && issue) begin
                op_q  <= bus.Funct3E;
                neg_q <= a_sign ^ b_sign;
                if (bus.Funct3E == MAC_F3_MACCLR)
                    result_q <= acc_q[XLEN-1:0];
                else if (!is_mul_op)
                    result_q <= acc_q[W2-1:XLEN];  // MACRDH and unused encodings
            end

            if (state_q == ADD && !bus.FlushE) begin
                acc_pend_q <= sum;
                result_q   <= sum[XLEN-1:0];
            end

            // The accumulator changes only when the instruction leaves Execute,
            // so a flushed or stalled instruction never disturbs it.
            if (commit) begin
                if (op_q == MAC_F3_MACCLR) acc_q <= '0;
                else if (mac_is_mul(op_q)) acc_q <= acc_pend_q;
            end
        end
    end

    // ------------------------------------------------- M and W pipe registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_m_q  <= 1'b0;
            result_m_q <= '0;
        end else if (bus.FlushM) begin
            valid_m_q  <= 1'b0;
        end else if (!bus.StallM) begin
            valid_m_q  <= commit;
            result_m_q <= result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_w_q  <= 1'b0;
            result_w_q <= '0;
        end else if (bus.FlushW) begin
            valid_w_q  <= 1'b0;
        end else if (!bus.StallW) begin
            valid_w_q  <= valid_m_q;
            result_w_q <= result_m_q;
        end
    end

    assign bus.MACValidW  = valid_w_q;
    assign bus.MACResultW = result_w_q;

endmodule

// File: tb/tb_mac_unit.sv
// -----------------------------------------------------------------------------
// tb_mac_unit
// Self-checking bench for mac_unit (RV64). Directed scenarios followed by a
// random instruction stream, checked against an arithmetic accumulator model.
// -----------------------------------------------------------------------------
module tb_mac_unit;
    import mac_unit_pkg::*;

    localparam int XLEN      = 64;
    localparam int MUL_BUSY  = XLEN / 8 + 2;
    localparam int BUSY_MAX  = 40;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference accumulator: the architectural value after every completed op.
    logic [127:0] acc_model = '0;

    mac_unit_if #(.XLEN(XLEN)) bus ();

    mac_unit #(.P(CVW_RV64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: cross a rising edge and land just after the falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Architectural model of one MAC-family instruction.
    task automatic model(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int busy);
        logic signed [127:0] sa, sb;
        logic [127:0]        prod;
        case (f3)
            MAC_F3_MAC: begin
                sa = $signed(a);
                sb = $signed(b);
                prod = sa * sb;
                acc_model = acc_model + prod;
                res  = acc_model[63:0];
                busy = MUL_BUSY;
            end
            MAC_F3_MACU: begin
                prod = {64'd0, a} * {64'd0, b};
                acc_model = acc_model + prod;
                res  = acc_model[63:0];
                busy = MUL_BUSY;
            end
            MAC_F3_MACCLR: begin
                res  = acc_model[63:0];
                acc_model = '0;
                busy = 1;
            end
            default: begin
                res  = acc_model[127:64];
                busy = 1;
            end
        endcase
    endtask

    // Issue one instruction, optionally stall it in DONE, and follow its
    // result through to writeback.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] b, input int stall_cyc, output logic [63:0] obs);
        logic [63:0] exp_res;
        int          exp_busy;
        int          busy_cnt;
        busy_cnt = 0;
        model(f3, a, b, exp_res, exp_busy);

        bus.mac_validE     = 1'b1;
        bus.Funct3E        = f3;
        bus.ForwardedSrcAE = a;
        bus.ForwardedSrcBE = b;
        #1;
        while (bus.MACBusyE && busy_cnt < BUSY_MAX) begin
            busy_cnt++;
            tick();
        end
        check({tag, " busy cycles"}, 128'(busy_cnt), 128'(exp_busy));

        bus.StallE = (stall_cyc > 0);
        for (int i = 0; i < stall_cyc; i++) begin
            tick();
            check({tag, " busy while stalled in DONE"}, 128'(bus.MACBusyE), 128'(0));
        end
        bus.StallE = 1'b0;
        tick();  // exit edge has passed
        bus.mac_validE = 1'b0;
        check({tag, " valid W one cycle early"}, 128'(bus.MACValidW), 128'(0));
        tick();
        check({tag, " valid W"}, 128'(bus.MACValidW), 128'(1));
        check({tag, " result W"}, 128'(bus.MACResultW), 128'(exp_res));
        obs = bus.MACResultW;
        tick();
        check({tag, " valid W single pulse"}, 128'(bus.MACValidW), 128'(0));
    endtask

    initial begin
        logic [63:0] r;
        logic [63:0] ra, rb;
        logic [2:0]  f3;
        int          sel;

        // ----------------------------------------------------------- reset
        reset              = 1'b0;
        bus.mac_validE     = 1'b1;
        bus.Funct3E        = MAC_F3_MACRDH;
        bus.ForwardedSrcAE = '0;
        bus.ForwardedSrcBE = '0;
        bus.StallE         = 1'b0;
        bus.FlushE         = 1'b0;
        bus.StallM         = 1'b0;
        bus.FlushM         = 1'b0;
        bus.StallW         = 1'b0;
        bus.FlushW         = 1'b0;
        repeat (3) tick();
        check("reset busy in IDLE", 128'(bus.MACBusyE), 128'(1));
        check("reset valid W", 128'(bus.MACValidW), 128'(0));
        check("reset result W", 128'(bus.MACResultW), 128'(0));
        bus.mac_validE = 1'b0;
        reset = 1'b1;
        tick();

        // -------------------------------------------------- signed MAC 3*-5
        run_op("mac 3*-5", MAC_F3_MAC, 64'd3, -64'sd5, 0, r);
        check("mac 3*-5 literal", 128'(r), 128'(64'hFFFF_FFFF_FFFF_FFF1));
        run_op("rdh after mac", MAC_F3_MACRDH, '0, '0, 0, r);
        check("rdh after mac literal", 128'(r), 128'(64'hFFFF_FFFF_FFFF_FFFF));
        run_op("clr all-ones", MAC_F3_MACCLR, '0, '0, 0, r);

        // -------------------------------------------------- MACU max*max
        run_op("macu max", MAC_F3_MACU, '1, '1, 0, r);
        check("macu max low literal", 128'(r), 128'(64'h1));
        run_op("rdh after macu max", MAC_F3_MACRDH, '0, '0, 0, r);
        check("rdh after macu max literal", 128'(r), 128'(64'hFFFF_FFFF_FFFF_FFFE));

        // -------------------------------------------------- accumulator wrap
        run_op("preload all-ones", MAC_F3_MACU, 64'd2, '1, 0, r);
        run_op("wrap 1*1", MAC_F3_MACU, 64'd1, 64'd1, 0, r);
        check("wrap low literal", 128'(r), 128'(0));
        run_op("rdh after wrap", MAC_F3_MACRDH, '0, '0, 0, r);
        check("rdh after wrap literal", 128'(r), 128'(0));

        // -------------------------------------------------- MACCLR
        run_op("load 0x1234", MAC_F3_MACU, 64'h1234, 64'd1, 0, r);
        run_op("clr 0x1234", MAC_F3_MACCLR, '0, '0, 0, r);
        check("clr literal", 128'(r), 128'(64'h1234));
        run_op("rdh after clr", MAC_F3_MACRDH, '0, '0, 0, r);
        check("rdh after clr literal", 128'(r), 128'(0));
        run_op("mac 0*0 after clr", MAC_F3_MAC, '0, '0, 0, r);
        check("mac 0*0 literal", 128'(r), 128'(0));

        // -------------------------------------------------- unused encoding
        run_op("preload neg", MAC_F3_MAC, 64'h7FFF_0000_1234_5678, -64'sd99, 0, r);
        run_op("funct3 111 as rdh", 3'b111, '0, '0, 0, r);

        // -------------------------------------------------- flush in MUL
        bus.mac_validE     = 1'b1;
        bus.Funct3E        = MAC_F3_MAC;
        bus.ForwardedSrcAE = 64'h0123_4567_89AB_CDEF;
        bus.ForwardedSrcBE = 64'h0000_0000_0000_0777;
        #1;
        check("flush issue busy", 128'(bus.MACBusyE), 128'(1));
        repeat (5) tick();  // MUL, count 4
        check("flush busy in MUL", 128'(bus.MACBusyE), 128'(1));
        bus.FlushE = 1'b1;
        tick();
        bus.FlushE     = 1'b0;
        bus.mac_validE = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("flushed op never reaches W", 128'(bus.MACValidW), 128'(0));
            tick();
        end
        run_op("rdh after flush", MAC_F3_MACRDH, '0, '0, 0, r);
        run_op("low after flush", MAC_F3_MAC, '0, '0, 0, r);

        // -------------------------------------------------- stall in DONE
        run_op("mac stalled 3", MAC_F3_MAC, 64'hFFFF_FFFF_0000_0003, 64'h0000_0001_0000_0005, 3, r);
        run_op("rdh after stall", MAC_F3_MACRDH, '0, '0, 0, r);
        run_op("low after stall", MAC_F3_MACU, '0, '0, 0, r);

        // -------------------------------------------------- reset during ADD
        bus.mac_validE     = 1'b1;
        bus.Funct3E        = MAC_F3_MACU;
        bus.ForwardedSrcAE = 64'hDEAD_BEEF_0000_0001;
        bus.ForwardedSrcBE = 64'h0000_0000_0001_0000;
        #1;
        repeat (MUL_BUSY - 1) tick();  // ADD cycle
        check("busy in ADD", 128'(bus.MACBusyE), 128'(1));
        reset          = 1'b0;
        bus.mac_validE = 1'b0;
        tick();
        reset = 1'b1;
        acc_model = '0;
        check("after reset busy", 128'(bus.MACBusyE), 128'(0));
        check("after reset valid W", 128'(bus.MACValidW), 128'(0));
        check("after reset result W", 128'(bus.MACResultW), 128'(0));
        run_op("rdh after reset", MAC_F3_MACRDH, '0, '0, 0, r);
        check("rdh after reset literal", 128'(r), 128'(0));
        run_op("low after reset", MAC_F3_MAC, '0, '0, 0, r);
        check("low after reset literal", 128'(r), 128'(0));

        // -------------------------------------------------- random stream
        for (int k = 0; k < 24; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 3)      f3 = MAC_F3_MAC;
            else if (sel <= 6) f3 = MAC_F3_MACU;
            else if (sel == 7) f3 = MAC_F3_MACCLR;
            else if (sel == 8) f3 = MAC_F3_MACRDH;
            else               f3 = 3'($urandom_range(4, 7));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb = 64'($urandom_range(0, 255));
            run_op($sformatf("random %0d f3=%0d", k, f3), f3, ra, rb,
                   int'($urandom_range(0, 2)), r);
        end
        run_op("final rdh", MAC_F3_MACRDH, '0, '0, 0, r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
